// File: rtl/gty_lane_bringup_sequencer.sv
// Bring-up sequencer for one GTY lane running PRBS: PLL settle, lane reset pulse,
// reset-done and PRBS-lock waits with timeouts, run-time monitoring, retry and fault latch.
module gty_lane_bringup_sequencer #(
    parameter int PLL_SETTLE_CYCLES = 1024,
    parameter int RESET_CYCLES      = 16,
    parameter int DONE_TIMEOUT      = 65535,
    parameter int LOCK_TIMEOUT      = 65535,
    parameter int MAX_RETRIES       = 3,
    parameter int ERR_WIDTH         = 32
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear_counters,
    input  logic                 qpll_lock,
    input  logic                 tx_reset_done,
    input  logic                 rx_reset_done,
    input  logic                 rxprbslocked,
    input  logic                 rxprbserr,
    output logic                 gty_tx_reset,
    output logic                 gty_rx_reset,
    output logic                 prbs_cnt_reset,
    output logic [2:0]           state,
    output logic                 link_up,
    output logic                 fault,
    output logic [3:0]           retry_count,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [15:0]          lock_loss_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PLL  = 3'd1,
        S_RESET     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WAIT_PRBS = 3'd4,
        S_RUN       = 3'd5,
        S_RETRY     = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam int MAX_A = (PLL_SETTLE_CYCLES > RESET_CYCLES) ? PLL_SETTLE_CYCLES : RESET_CYCLES;
    localparam int MAX_B = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_C + 1);

    state_t        st, st_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          lock_loss;

    // One shared timer: settle count in WAIT_PLL, dwell/timeout elsewhere.
    // It only advances while the state is held, so every entry starts it at zero.
    always_comb begin
        st_nxt    = st;
        tmr_nxt   = '0;
        lock_loss = 1'b0;
        case (st)
            S_IDLE: st_nxt = S_WAIT_PLL;
            S_WAIT_PLL: begin
                if (qpll_lock) begin
                    if (tmr == TW'(PLL_SETTLE_CYCLES - 1)) st_nxt = S_RESET;
                    else                                   tmr_nxt = tmr + 1'b1;
                end
            end
            S_RESET: begin
                if (!qpll_lock)                          st_nxt = S_WAIT_PLL;
                else if (tmr == TW'(RESET_CYCLES - 1))   st_nxt = S_WAIT_DONE;
                else                                     tmr_nxt = tmr + 1'b1;
            end
            S_WAIT_DONE: begin
                if (!qpll_lock)                          st_nxt = S_WAIT_PLL;
                else if (tx_reset_done && rx_reset_done) st_nxt = S_WAIT_PRBS;
                else if (tmr == TW'(DONE_TIMEOUT - 1))   st_nxt = S_RETRY;
                else                                     tmr_nxt = tmr + 1'b1;
            end
            S_WAIT_PRBS: begin
                if (!qpll_lock)                          st_nxt = S_WAIT_PLL;
                else if (rxprbslocked)                   st_nxt = S_RUN;
                else if (tmr == TW'(LOCK_TIMEOUT - 1))   st_nxt = S_RETRY;
                else                                     tmr_nxt = tmr + 1'b1;
            end
            S_RUN: begin
                // PLL loss restarts from settle without spending a retry.
                if (!qpll_lock || !rxprbslocked) begin
                    lock_loss = 1'b1;
                    st_nxt    = !qpll_lock ? S_WAIT_PLL : S_RETRY;
                end
            end
            S_RETRY: st_nxt = (retry_count + 4'd1 == 4'(MAX_RETRIES)) ? S_FAULT : S_WAIT_PLL;
            S_FAULT: st_nxt = S_FAULT;
            default: st_nxt = S_IDLE;
        endcase
        if (!enable) begin
            st_nxt    = S_IDLE;
            tmr_nxt   = '0;
            lock_loss = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            st              <= S_IDLE;
            tmr             <= '0;
            gty_tx_reset    <= 1'b1;
            gty_rx_reset    <= 1'b1;
            prbs_cnt_reset  <= 1'b0;
            link_up         <= 1'b0;
            fault           <= 1'b0;
            retry_count     <= '0;
            err_count       <= '0;
            lock_loss_count <= '0;
        end else begin
            st             <= st_nxt;
            tmr            <= tmr_nxt;
            // Outputs are decoded from the next state so they change with the state register.
            gty_tx_reset   <= !(st_nxt inside {S_WAIT_DONE, S_WAIT_PRBS, S_RUN});
            gty_rx_reset   <= !(st_nxt inside {S_WAIT_DONE, S_WAIT_PRBS, S_RUN});
            prbs_cnt_reset <= (st_nxt == S_RUN) && (st != S_RUN);
            link_up        <= (st_nxt == S_RUN);
            fault          <= (st_nxt == S_FAULT);

            if (st_nxt == S_IDLE)    retry_count <= '0;
            else if (st == S_RETRY)  retry_count <= retry_count + 4'd1;

            if (clear_counters)
                err_count <= '0;
            else if (st == S_RUN && rxprbserr && err_count != {ERR_WIDTH{1'b1}})
                err_count <= err_count + 1'b1;

            if (clear_counters)
                lock_loss_count <= '0;
            else if (lock_loss && lock_loss_count != 16'hFFFF)
                lock_loss_count <= lock_loss_count + 16'd1;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_gty_lane_bringup_sequencer.sv
// Directed bring-up scenarios plus randomized inputs, all outputs compared every cycle
// against a cycle-level behavioural model of the sequencer.
module tb_gty_lane_bringup_sequencer;

    localparam int PLL  = 4;
    localparam int RSTC = 3;
    localparam int DTO  = 10;
    localparam int LTO  = 10;
    localparam int MAXR = 2;
    localparam int EW   = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic rst_n, enable, clear_counters, qpll_lock;
    logic tx_reset_done, rx_reset_done, rxprbslocked, rxprbserr;
    logic gty_tx_reset, gty_rx_reset, prbs_cnt_reset, link_up, fault;
    logic [2:0]    state;
    logic [3:0]    retry_count;
    logic [EW-1:0] err_count;
    logic [15:0]   lock_loss_count;

    gty_lane_bringup_sequencer #(
        .PLL_SETTLE_CYCLES(PLL), .RESET_CYCLES(RSTC), .DONE_TIMEOUT(DTO),
        .LOCK_TIMEOUT(LTO), .MAX_RETRIES(MAXR), .ERR_WIDTH(EW)
    ) dut (
        .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .clear_counters(clear_counters),
        .qpll_lock(qpll_lock), .tx_reset_done(tx_reset_done), .rx_reset_done(rx_reset_done),
        .rxprbslocked(rxprbslocked), .rxprbserr(rxprbserr),
        .gty_tx_reset(gty_tx_reset), .gty_rx_reset(gty_rx_reset),
        .prbs_cnt_reset(prbs_cnt_reset), .state(state), .link_up(link_up), .fault(fault),
        .retry_count(retry_count), .err_count(err_count), .lock_loss_count(lock_loss_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase number, cycles spent in the phase (lock streak while settling),
    // retries this attempt, and the two saturating statistics.
    int m_st = 0, m_prev = 0, m_dwell = 0, m_retry = 0, m_err = 0, m_ll = 0;

    task automatic model_step();
        int ns;
        if (!rst_n) begin
            m_st = 0; m_prev = 0; m_dwell = 0; m_retry = 0; m_err = 0; m_ll = 0;
        end else begin
            ns = m_st;
            case (m_st)
                0: ns = 1;
                1: if (qpll_lock && m_dwell + 1 >= PLL) ns = 2;
                2: if (!qpll_lock) ns = 1; else if (m_dwell + 1 >= RSTC) ns = 3;
                3: if (!qpll_lock) ns = 1; else if (tx_reset_done && rx_reset_done) ns = 4;
                   else if (m_dwell + 1 >= DTO) ns = 6;
                4: if (!qpll_lock) ns = 1; else if (rxprbslocked) ns = 4 + 1;
                   else if (m_dwell + 1 >= LTO) ns = 6;
                5: if (!qpll_lock) ns = 1; else if (!rxprbslocked) ns = 6;
                6: ns = (m_retry + 1 == MAXR) ? 7 : 1;
                default: ns = m_st;
            endcase
            if (!enable) ns = 0;

            if (clear_counters) m_ll = 0;
            else if (enable && m_st == 5 && (!qpll_lock || !rxprbslocked) && m_ll < 65535) m_ll++;
            if (clear_counters) m_err = 0;
            else if (m_st == 5 && rxprbserr && m_err < ERR_MAX) m_err++;

            if (ns == 0)        m_retry = 0;
            else if (m_st == 6) m_retry++;

            if (ns != m_st)     m_dwell = 0;
            else if (m_st == 1) m_dwell = qpll_lock ? m_dwell + 1 : 0;
            else                m_dwell++;

            m_prev = m_st;
            m_st   = ns;
        end
    endtask

    task automatic compare_all();
        logic rst_exp;
        rst_exp = !(m_st == 3 || m_st == 4 || m_st == 5);
        chk("state",           state,           m_st);
        chk("gty_tx_reset",    gty_tx_reset,    rst_exp);
        chk("gty_rx_reset",    gty_rx_reset,    rst_exp);
        chk("link_up",         link_up,         m_st == 5);
        chk("fault",           fault,           m_st == 7);
        chk("prbs_cnt_reset",  prbs_cnt_reset,  m_st == 5 && m_prev != 5);
        chk("retry_count",     retry_count,     m_retry);
        chk("err_count",       err_count,       m_err);
        chk("lock_loss_count", lock_loss_count, m_ll);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; clear_counters = 1'b0; qpll_lock = 1'b0;
        tx_reset_done = 1'b0; rx_reset_done = 1'b0; rxprbslocked = 1'b0; rxprbserr = 1'b0;
        cyc(1);
        chk("rst_state", state, 0);
        chk("rst_tx_reset", gty_tx_reset, 1);
        rst_n = 1'b1;
    endtask

    initial begin
        // Bring-up sequence, reset deassert timing and RUN entry pulse
        do_reset();
        enable = 1'b1; qpll_lock = 1'b1;
        cyc(1);                 chk("s1_wait_pll", state, 1);
        cyc(PLL);               chk("s1_reset", state, 2);
        cyc(RSTC - 1);          chk("s1_reset_hold", gty_tx_reset, 1);
        cyc(1);                 chk("s1_wait_done", state, 3);
                                chk("s1_tx_released", gty_tx_reset, 0);
        cyc(2); tx_reset_done = 1'b1; rx_reset_done = 1'b1;
        cyc(1);                 chk("s1_wait_prbs", state, 4);
        cyc(2); rxprbslocked = 1'b1;
        cyc(1);                 chk("s1_run", state, 5);
                                chk("s1_link_up", link_up, 1);
                                chk("s1_pulse", prbs_cnt_reset, 1);
        cyc(1);                 chk("s1_pulse_once", prbs_cnt_reset, 0);

        // Error counting, clear-beats-increment, saturation
        rxprbserr = 1'b1; cyc(5); rxprbserr = 1'b0;
        chk("s2_err5", err_count, 5);
        rxprbserr = 1'b1; clear_counters = 1'b1; cyc(1);
        chk("s2_clear_wins", err_count, 0);
        clear_counters = 1'b0; cyc(ERR_MAX + 40); rxprbserr = 1'b0;
        chk("s2_err_sat", err_count, ERR_MAX);

        // One-cycle PRBS lock drop in RUN
        rxprbslocked = 1'b0; cyc(1);
        chk("s4_retry_state", state, 6);
        chk("s4_lock_loss", lock_loss_count, 1);
        rxprbslocked = 1'b1; cyc(1);
        chk("s4_wait_pll", state, 1);
        chk("s4_retry1", retry_count, 1);

        // Reset-done timeout twice -> FAULT, then enable drop
        do_reset();
        enable = 1'b1; qpll_lock = 1'b1; tx_reset_done = 1'b1;
        cyc(1 + PLL + RSTC);    chk("s3_wait_done", state, 3);
        cyc(DTO - 1);           chk("s3_not_yet", state, 3);
        cyc(1);                 chk("s3_retry", state, 6);
        cyc(1);                 chk("s3_retry1", retry_count, 1);
        cyc(PLL + RSTC + DTO);  chk("s3_retry2_state", state, 6);
        cyc(1);                 chk("s3_fault_state", state, 7);
                                chk("s3_fault", fault, 1);
                                chk("s3_retry2", retry_count, 2);
                                chk("s3_fault_resets", gty_rx_reset, 1);
        cyc(3);                 chk("s3_fault_held", state, 7);
        enable = 1'b0; cyc(1);  chk("s3_idle", state, 0);
                                chk("s3_retry0", retry_count, 0);

        // Done arriving on the final timeout cycle wins
        enable = 1'b1;
        cyc(1 + PLL + RSTC);
        cyc(DTO - 1); rx_reset_done = 1'b1;
        cyc(1);                 chk("s3b_success_wins", state, 4);
        rx_reset_done = 1'b0;

        // qpll glitch at settle count 3 restarts the settle counter
        do_reset();
        enable = 1'b1; qpll_lock = 1'b1;
        cyc(1); cyc(PLL - 1);
        qpll_lock = 1'b0; cyc(1);  chk("s5_glitch", state, 1);
        qpll_lock = 1'b1; cyc(PLL - 1); chk("s5_not_yet", state, 1);
        cyc(1);                    chk("s5_reset", state, 2);

        // rst_n during WAIT_PRBS with nonzero counters
        do_reset();
        enable = 1'b1; qpll_lock = 1'b1; tx_reset_done = 1'b1; rx_reset_done = 1'b1;
        cyc(1 + PLL + RSTC + 1);
        rxprbslocked = 1'b1; rxprbserr = 1'b1; cyc(3);
        rxprbslocked = 1'b0; rxprbserr = 1'b0;
        cyc(1 + 1 + PLL + RSTC + 1); chk("s6_wait_prbs", state, 4);
        cyc(2);
        rst_n = 1'b0; cyc(1);
        chk("s6_state", state, 0);
        chk("s6_resets", gty_tx_reset, 1);
        chk("s6_err", err_count, 0);
        chk("s6_ll", lock_loss_count, 0);
        rst_n = 1'b1;

        // Randomized inputs
        for (int i = 0; i < 5000; i++) begin
            rst_n          = ($urandom_range(0, 499) != 0);
            enable         = ($urandom_range(0, 59) != 0);
            clear_counters = ($urandom_range(0, 79) == 0);
            qpll_lock      = ($urandom_range(0, 29) != 0);
            tx_reset_done  = ($urandom_range(0, 3) != 0);
            rx_reset_done  = ($urandom_range(0, 9) == 0);
            rxprbslocked   = ($urandom_range(0, 14) != 0);
            rxprbserr      = ($urandom_range(0, 3) == 0);
            cyc(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
